// File: rtl/video_write_queue.sv
// Pixel write queue between the WVM execute path and single-port video memory.
// Entries drain into memory only while the VGA controller is in blanking.
module video_write_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]   iWriteAddress,
    input  logic [DATA_WIDTH-1:0]   iColor,
    input  logic                    iBlank,
    input  logic [ADDR_WIDTH-1:0]   iScanAddress,
    output logic [ADDR_WIDTH-1:0]   oMemAddress,
    output logic [DATA_WIDTH-1:0]   oMemData,
    output logic                    oMemWriteEnable,
    output logic [$clog2(DEPTH):0]  oCount,
    output logic                    oFull,
    output logic                    oEmpty,
    output logic                    oOverflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic {SCAN, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addrMem  [DEPTH];
    logic [DATA_WIDTH-1:0]   colorMem [DEPTH];
    logic [PW-1:0]           wrPtr;
    logic [PW-1:0]           rdPtr;
    logic [CW-1:0]           nextCount;
    logic                    nonEmpty;
    logic                    hasRoom;
    logic                    pop;
    logic                    push;
    logic                    lastPop;

    assign nonEmpty = (oCount != '0);
    assign hasRoom  = (oCount != FullCount);
    assign pop      = (state == DRAIN) && iBlank && nonEmpty;
    // A pop frees a slot this cycle, so a full queue still accepts a push.
    assign push     = iWriteEnable && (hasRoom || pop);
    assign lastPop  = pop && !push && (oCount == CW'(1));

    always_comb begin
        nextCount = oCount;
        if (push && !pop)
            nextCount = oCount + CW'(1);
        else if (pop && !push)
            nextCount = oCount - CW'(1);
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            addrMem[wrPtr]  <= iWriteAddress;
            colorMem[wrPtr] <= iColor;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= SCAN;
            wrPtr           <= '0;
            rdPtr           <= '0;
            oCount          <= '0;
            oFull           <= 1'b0;
            oEmpty          <= 1'b1;
            oOverflow       <= 1'b0;
            oMemAddress     <= '0;
            oMemData        <= '0;
            oMemWriteEnable <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PW'(1);
            if (pop)
                rdPtr <= rdPtr + PW'(1);
            oCount <= nextCount;
            oFull  <= (nextCount == FullCount);
            oEmpty <= (nextCount == '0);
            if (iWriteEnable && !push)
                oOverflow <= 1'b1;

            if (pop) begin
                oMemWriteEnable <= 1'b1;
                oMemAddress     <= addrMem[rdPtr];
                oMemData        <= colorMem[rdPtr];
            end else begin
                oMemWriteEnable <= 1'b0;
                oMemAddress     <= iScanAddress;
                oMemData        <= '0;
            end

            unique case (state)
                SCAN: begin
                    if (iBlank && nonEmpty)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!iBlank || lastPop)
                        state <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_video_write_queue.sv
// Directed bench for video_write_queue: stimulus queues expected strobes,
// a negedge monitor checks every memory-port cycle against them.
module tb_video_write_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int DW    = 3;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           iWriteEnable;
    logic [AW-1:0]  iWriteAddress;
    logic [DW-1:0]  iColor;
    logic           iBlank;
    logic [AW-1:0]  iScanAddress;
    logic [AW-1:0]  oMemAddress;
    logic [DW-1:0]  oMemData;
    logic           oMemWriteEnable;
    logic [3:0]     oCount;
    logic           oFull;
    logic           oEmpty;
    logic           oOverflow;

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] sb[$];
    logic [AW-1:0]    lastScan;
    logic             lastReset;
    bit               monOn = 0;

    always #5 Clock = ~Clock;

    video_write_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iWriteEnable(iWriteEnable),
        .iWriteAddress(iWriteAddress),
        .iColor(iColor),
        .iBlank(iBlank),
        .iScanAddress(iScanAddress),
        .oMemAddress(oMemAddress),
        .oMemData(oMemData),
        .oMemWriteEnable(oMemWriteEnable),
        .oCount(oCount),
        .oFull(oFull),
        .oEmpty(oEmpty),
        .oOverflow(oOverflow)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock) begin
        lastScan  <= iScanAddress;
        lastReset <= Reset;
    end

    always @(negedge Clock) begin
        logic [AW+DW-1:0] exp;
        if (monOn) begin
            if (lastReset) begin
                check("reset_we", 32'(oMemWriteEnable), 0);
                check("reset_addr", 32'(oMemAddress), 0);
            end else if (oMemWriteEnable) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got addr %0h expected none", oMemAddress);
                end else begin
                    exp = sb.pop_front();
                    check("strobe_addr", 32'(oMemAddress), 32'(exp[AW+DW-1:DW]));
                    check("strobe_data", 32'(oMemData), 32'(exp[DW-1:0]));
                end
            end else begin
                check("scan_addr", 32'(oMemAddress), 32'(lastScan));
                check("scan_data", 32'(oMemData), 0);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        tick();
        sb.delete();
        Reset = 1'b0;
    endtask

    task automatic pushOne(logic [AW-1:0] a, logic [DW-1:0] c, bit accept);
        iWriteEnable  = 1'b1;
        iWriteAddress = a;
        iColor        = c;
        if (accept)
            sb.push_back({a, c});
        tick();
        iWriteEnable = 1'b0;
    endtask

    task automatic waitEmpty(int bound);
        int n = 0;
        while (!oEmpty && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", 32'(oEmpty), 1);
    endtask

    initial begin
        Reset         = 1'b1;
        iWriteEnable  = 1'b0;
        iWriteAddress = '0;
        iColor        = '0;
        iBlank        = 1'b0;
        iScanAddress  = '0;
        tick();
        monOn = 1;
        tick();
        check("rst_count", 32'(oCount), 0);
        check("rst_empty", 32'(oEmpty), 1);
        check("rst_full", 32'(oFull), 0);
        check("rst_ovf", 32'(oOverflow), 0);
        check("rst_we", 32'(oMemWriteEnable), 0);
        check("rst_addr", 32'(oMemAddress), 0);
        Reset = 1'b0;

        // single push while visible: no strobe, scan address passes through
        iScanAddress = 10'h123;
        pushOne(10'h015, 3'b101, 1);
        check("t1_count", 32'(oCount), 1);
        check("t1_empty", 32'(oEmpty), 0);
        for (int i = 0; i < 4; i++) begin
            iScanAddress = AW'(10'h200 + i * 7);
            tick();
            check("t1_we", 32'(oMemWriteEnable), 0);
            check("t1_count_hold", 32'(oCount), 1);
        end
        doReset();

        // three entries drained in order after blanking starts
        pushOne(10'h001, 3'd1, 1);
        pushOne(10'h002, 3'd2, 1);
        pushOne(10'h003, 3'd3, 1);
        iBlank = 1'b1;
        tick();
        check("t2_c1_we", 32'(oMemWriteEnable), 0);
        tick();
        check("t2_c2_we", 32'(oMemWriteEnable), 1);
        check("t2_c2_addr", 32'(oMemAddress), 32'h001);
        tick();
        check("t2_c3_addr", 32'(oMemAddress), 32'h002);
        tick();
        check("t2_c4_addr", 32'(oMemAddress), 32'h003);
        check("t2_empty", 32'(oEmpty), 1);
        tick();
        check("t2_c5_we", 32'(oMemWriteEnable), 0);
        check("t2_sb", 32'(sb.size()), 0);
        iBlank = 1'b0;
        tick();

        // fill, overflow, sticky flag
        for (int i = 0; i < DEPTH; i++)
            pushOne(AW'(10'h100 + i), DW'(i), 1);
        check("t3_full", 32'(oFull), 1);
        check("t3_count", 32'(oCount), 8);
        pushOne(10'h3AA, 3'd2, 0);
        check("t3_ovf", 32'(oOverflow), 1);
        check("t3_count_drop", 32'(oCount), 8);
        repeat (3) tick();
        check("t3_ovf_sticky", 32'(oOverflow), 1);
        doReset();
        check("t3_ovf_clr", 32'(oOverflow), 0);
        check("t3_count_clr", 32'(oCount), 0);

        // full queue with a push in every pop cycle
        for (int i = 0; i < DEPTH; i++)
            pushOne(AW'(10'h040 + i), DW'(7 - i), 1);
        check("t4_full", 32'(oFull), 1);
        iBlank = 1'b1;
        tick();
        iWriteEnable  = 1'b1;
        iWriteAddress = 10'h3FF;
        iColor        = 3'd7;
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back({10'h3FF, 3'd7});
            tick();
            check("t4_count", 32'(oCount), 8);
            check("t4_ovf", 32'(oOverflow), 0);
        end
        iWriteEnable = 1'b0;
        waitEmpty(20);
        tick();
        check("t4_sb", 32'(sb.size()), 0);
        iBlank = 1'b0;
        tick();

        // blanking too short to drain everything
        doReset();
        for (int i = 0; i < 4; i++)
            pushOne(AW'(10'h080 + i), DW'(i + 1), 1);
        iBlank = 1'b1;
        tick();
        tick();
        iBlank = 1'b0;
        check("t5_count", 32'(oCount), 3);
        repeat (3) tick();
        check("t5_count_hold", 32'(oCount), 3);
        check("t5_sb", 32'(sb.size()), 3);
        iBlank = 1'b1;
        waitEmpty(10);
        tick();
        iBlank = 1'b0;
        check("t5_sb_done", 32'(sb.size()), 0);
        tick();

        // reset mid-drain discards the remainder
        for (int i = 0; i < 6; i++)
            pushOne(AW'(10'h2C0 + i), DW'(i), 1);
        iBlank = 1'b1;
        tick();
        tick();
        check("t6_count", 32'(oCount), 5);
        doReset();
        check("t6_count_rst", 32'(oCount), 0);
        check("t6_empty_rst", 32'(oEmpty), 1);
        check("t6_we_rst", 32'(oMemWriteEnable), 0);
        repeat (4) tick();
        check("t6_count_after", 32'(oCount), 0);
        iBlank = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
